serial_alu: RTL and testbench
=============================

SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter: WIDTH, default 64, operand and result width in bits (legal range 2..64).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 ALUOp  input  4  operation code; captured on the accepted start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse marking a valid Result.
REQ-010 Result  output  WIDTH  final result; held until the next accepted start.
REQ-011 Zero  output  1  high when Result == 0; valid with done and held afterwards.
REQ-012 CarryOut  output  1  carry out of bit WIDTH-1; held until the next accepted start.

Function
REQ-013 The block SHALL compute one result bit per clock, LSB first, using one internal 1-bit slice.
- ainv = ALUOp[3]; the slice operand is a_i^ainv.
- binv = ALUOp[2]; the slice operand is b_i^binv.
REQ-014 The slice SHALL select its bit function from the captured ALUOp:
- 0000: AND
- 0001: OR
- 1100: NOR of the un-inverted operands, i.e. AND of the inverted ones
- all other codes: sum = x^y^c
REQ-015 On every sum-path bit, the carry register SHALL load (x&y)|(x&c)|(y&c); logic ops SHALL leave the carry register unchanged.
REQ-016 The carry register SHALL initialise to ALUOp[2] on the accepted start, so that 0110 yields A-B in two's complement.
REQ-017 The FSM SHALL have three states, IDLE, RUN and DONE:
- IDLE->RUN on start.
- RUN->DONE after exactly WIDTH bit cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-018 On the accepted start, the block SHALL latch a, b and ALUOp, clear the bit counter and clear the result shift register.
REQ-019 Each RUN cycle SHALL shift the slice output into Result[WIDTH-1] with a right shift, so that after WIDTH cycles bit 0 is in Result[0].
REQ-020 Latency SHALL be WIDTH+1 clocks from the start edge to done high; busy SHALL be high for exactly WIDTH cycles.
REQ-021 done SHALL be high only in DONE; busy SHALL be high only in RUN; done and busy SHALL never both be high.
REQ-022 start while in RUN or DONE SHALL be ignored, and the latched operands SHALL be unaffected.
REQ-023 Changes on a, b or ALUOp after the accepted start SHALL not affect the in-flight operation.
REQ-024 CarryOut SHALL equal the carry register after the final bit; for logic ops it SHALL retain the initial value from REQ-016.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during RUN.
REQ-026 start asserted in the DONE cycle SHALL be ignored; a new request is accepted no earlier than the following IDLE cycle.

Reset
REQ-027 While reset is high, the block SHALL enter IDLE and drive busy=0, done=0, Result=0, Zero=1 and CarryOut=0, and SHALL clear the counter, carry and operand registers.
REQ-028 Reset SHALL take priority over start on the same edge.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the next start SHALL begin a fresh operation.

Verification
REQ-030 WIDTH=64, ALUOp=0010, a=0xFFFFFFFFFFFFFFFF, b=1, start -> done at cycle 65, Result=0, Zero=1, CarryOut=1.
REQ-031 ALUOp=0110, a=5, b=7 -> Result=0xFFFFFFFFFFFFFFFE, Zero=0, CarryOut=0; a=7, b=7 -> Result=0, Zero=1, CarryOut=1.
REQ-032 Logic ops with a=0xF0F0, b=0xFF00:
- 0000 -> 0xF000
- 0001 -> 0xFFF0
- 1100 -> 0xFFFFFFFFFFFF000F
REQ-033 start re-pulsed and a changed at cycles 10 and 64 of RUN -> result unchanged, a single done pulse, busy width exactly 64.
REQ-034 reset at RUN cycle 30 -> no done, all outputs at reset values next cycle; a subsequent 0010 with a=3, b=4 -> Result=7 after 65 cycles.
REQ-035 WIDTH=8, ALUOp=0010, a=0x80, b=0x80 -> done at cycle 9, Result=0, Zero=1, CarryOut=1.

Source files
------------

// File: rtl/serial_alu_if.sv
// Request/response bundle for serial_alu: operands and opcode in, status and result out.
interface serial_alu_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUOp;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             CarryOut;

  modport master (
    output start, a, b, ALUOp,
    input  busy, done, Result, Zero, CarryOut
  );

  modport slave (
    input  start, a, b, ALUOp,
    output busy, done, Result, Zero, CarryOut
  );
endinterface

// File: rtl/serial_alu.sv
// Bit-serial ALU: one 1-bit slice evaluated LSB first, one bit per clock, WIDTH clocks per op.
module serial_alu #(
  parameter int unsigned WIDTH = 64
) (
  input logic         clk,
  input logic         reset,
  serial_alu_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]       op_q;
  logic             carry_q;
  logic             accept;
  logic             x, y, slice_bit, slice_carry;

  assign accept = (state_q == StIdle) && bus.start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand bit 0 is always the current bit: operand copies shift right as they are consumed.
  always_comb begin
    x           = a_q[0] ^ op_q[3];
    y           = b_q[0] ^ op_q[2];
    slice_bit   = 1'b0;
    slice_carry = carry_q;
    case (op_q)
      4'b0000: slice_bit = x & y;
      4'b0001: slice_bit = x | y;
      4'b1100: slice_bit = x & y;
      default: begin
        slice_bit   = x ^ y ^ carry_q;
        slice_carry = (x & y) | (x & carry_q) | (y & carry_q);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        op_q    <= bus.ALUOp;
        carry_q <= bus.ALUOp[2];
        cnt_q   <= '0;
        res_q   <= '0;
      end else if (state_q == StRun) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        carry_q <= slice_carry;
        res_q   <= {slice_bit, res_q[WIDTH-1:1]};
        cnt_q   <= cnt_q + CntW'(1);
      end
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.Result   = res_q;
  assign bus.Zero     = ~|res_q;
  assign bus.CarryOut = carry_q;
endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: arithmetic reference model plus directed vectors on 64- and 8-bit instances.
module tb_serial_alu;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_alu_if #(.WIDTH(64)) if64 ();
  serial_alu_if #(.WIDTH(8))  if8 ();

  serial_alu #(.WIDTH(64)) u_alu64 (.clk(clk), .reset(reset), .bus(if64.slave));
  serial_alu #(.WIDTH(8))  u_alu8  (.clk(clk), .reset(reset), .bus(if8.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Expected {carry, result} for the operation in flight on each instance.
  logic [64:0] exp64 = '0;
  logic [64:0] exp8  = '0;

  logic [63:0] got_res;
  logic        got_z, got_c;
  int          got_lat, got_bw, got_dn;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Word-level reference: plain two's-complement add with optional inversions, or bitwise logic.
  function automatic logic [64:0] model(input logic [3:0] op, input logic [63:0] av,
                                        input logic [63:0] bv, input int w);
    logic [63:0] mask;
    logic [63:0] x, y, r;
    logic [64:0] s;
    logic        c;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (op)
      4'b0000: begin r = av & bv;    c = 1'b0; end
      4'b0001: begin r = av | bv;    c = 1'b0; end
      4'b1100: begin r = ~(av | bv); c = 1'b1; end
      default: begin
        x = op[3] ? ~av : av;
        y = op[2] ? ~bv : bv;
        s = {1'b0, x & mask} + {1'b0, y & mask} + {64'd0, op[2]};
        r = s[63:0];
        c = s[w];
      end
    endcase
    return {c, r & mask};
  endfunction

  always @(negedge clk) begin
    if (if64.done || if64.busy) chk("excl64", {63'd0, if64.done & if64.busy}, 64'd0);
    if (if8.done || if8.busy)   chk("excl8", {63'd0, if8.done & if8.busy}, 64'd0);
    if (if64.done) begin
      chk("model64_result", if64.Result, exp64[63:0]);
      chk("model64_zero", {63'd0, if64.Zero}, {63'd0, exp64[63:0] == 64'd0});
      chk("model64_carry", {63'd0, if64.CarryOut}, {63'd0, exp64[64]});
    end
    if (if8.done) begin
      chk("model8_result", {56'd0, if8.Result}, {56'd0, exp8[7:0]});
      chk("model8_zero", {63'd0, if8.Zero}, {63'd0, exp8[7:0] == 8'd0});
      chk("model8_carry", {63'd0, if8.CarryOut}, {63'd0, exp8[64]});
    end
  end

  // mode 0: plain op; mode 1: re-pulse start/change inputs mid-run and in DONE; mode 2: reset at 30
  task automatic run64(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv,
                       input int mode);
    @(negedge clk);
    if64.start = 1'b1;
    if64.ALUOp = op;
    if64.a     = av;
    if64.b     = bv;
    exp64      = model(op, av, bv, 64);
    got_lat = -1; got_bw = 0; got_dn = 0;
    for (int lat = 1; lat <= 70; lat++) begin
      @(negedge clk);
      if64.start = 1'b0;
      if (if64.busy) got_bw++;
      if (if64.done) begin
        got_dn++;
        if (got_lat < 0) begin
          got_lat = lat;
          got_res = if64.Result;
          got_z   = if64.Zero;
          got_c   = if64.CarryOut;
        end
      end
      if (mode == 1 && (lat == 10 || lat == 64 || lat == 65)) begin
        if64.start = 1'b1;
        if64.a     = ~av;
        if64.b     = ~bv;
        if64.ALUOp = 4'b0000;
      end
      if (mode == 2 && lat == 30) reset = 1'b1;
      if (mode == 2 && lat == 31) begin
        reset = 1'b0;
        chk("abort_busy", {63'd0, if64.busy}, 64'd0);
        chk("abort_done", {63'd0, if64.done}, 64'd0);
        chk("abort_result", if64.Result, 64'd0);
        chk("abort_zero", {63'd0, if64.Zero}, 64'd1);
        chk("abort_carry", {63'd0, if64.CarryOut}, 64'd0);
      end
    end
    if (mode != 2) chk("held_result", if64.Result, got_res);
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    if8.start = 1'b1;
    if8.ALUOp = op;
    if8.a     = av;
    if8.b     = bv;
    exp8      = model(op, {56'd0, av}, {56'd0, bv}, 8);
    got_lat = -1; got_bw = 0; got_dn = 0;
    for (int lat = 1; lat <= 14; lat++) begin
      @(negedge clk);
      if8.start = 1'b0;
      if (if8.busy) got_bw++;
      if (if8.done) begin
        got_dn++;
        if (got_lat < 0) begin
          got_lat = lat;
          got_res = {56'd0, if8.Result};
          got_z   = if8.Zero;
          got_c   = if8.CarryOut;
        end
      end
    end
  endtask

  task automatic expect_op(input string name, input logic [63:0] res, input logic z,
                           input logic c, input int lat, input int bw, input int dn);
    chk({name, "_result"}, got_res, res);
    chk({name, "_zero"}, {63'd0, got_z}, {63'd0, z});
    chk({name, "_carry"}, {63'd0, got_c}, {63'd0, c});
    chk({name, "_latency"}, 64'(got_lat), 64'(lat));
    chk({name, "_busywidth"}, 64'(got_bw), 64'(bw));
    chk({name, "_donecount"}, 64'(got_dn), 64'(dn));
  endtask

  initial begin
    reset = 1'b1;
    if64.start = 1'b1; if64.a = 64'h1; if64.b = 64'h1; if64.ALUOp = 4'b0010;
    if8.start  = 1'b1; if8.a  = 8'h1;  if8.b  = 8'h1;  if8.ALUOp  = 4'b0010;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, if64.busy}, 64'd0);
    chk("rst_done", {63'd0, if64.done}, 64'd0);
    chk("rst_result", if64.Result, 64'd0);
    chk("rst_zero", {63'd0, if64.Zero}, 64'd1);
    chk("rst_carry", {63'd0, if64.CarryOut}, 64'd0);
    chk("rst_busy8", {63'd0, if8.busy}, 64'd0);
    chk("rst_zero8", {63'd0, if8.Zero}, 64'd1);
    if64.start = 1'b0;
    if8.start  = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    chk("idle_busy", {63'd0, if64.busy}, 64'd0);

    run64(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    expect_op("add_wrap", 64'd0, 1'b1, 1'b1, 65, 64, 1);
    run64(4'b0110, 64'd5, 64'd7, 0);
    expect_op("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 65, 64, 1);
    run64(4'b0110, 64'd7, 64'd7, 0);
    expect_op("sub_eq", 64'd0, 1'b1, 1'b1, 65, 64, 1);
    run64(4'b0000, 64'hF0F0, 64'hFF00, 0);
    expect_op("and", 64'hF000, 1'b0, 1'b0, 65, 64, 1);
    run64(4'b0001, 64'hF0F0, 64'hFF00, 0);
    expect_op("or", 64'hFFF0, 1'b0, 1'b0, 65, 64, 1);
    run64(4'b1100, 64'hF0F0, 64'hFF00, 0);
    expect_op("nor", 64'hFFFF_FFFF_FFFF_000F, 1'b0, 1'b1, 65, 64, 1);

    run64(4'b0010, 64'h1234, 64'h1111, 1);
    expect_op("repulse", 64'h2345, 1'b0, 1'b0, 65, 64, 1);
    if64.a = 64'd0; if64.b = 64'd0;

    run64(4'b0010, 64'hDEAD, 64'hBEEF, 2);
    chk("abort_donecount", 64'(got_dn), 64'd0);
    run64(4'b0010, 64'd3, 64'd4, 0);
    expect_op("after_abort", 64'd7, 1'b0, 1'b0, 65, 64, 1);

    run8(4'b0010, 8'h80, 8'h80);
    expect_op("w8_add", 64'd0, 1'b1, 1'b1, 9, 8, 1);
    run8(4'b0110, 8'h03, 8'h05);
    expect_op("w8_sub", 64'hFE, 1'b0, 1'b0, 9, 8, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
